parity_block_codec: RTL and testbench
=====================================

// Module: parity_block_codec
// PURPOSE
//  Streaming parity generator/checker with block-level LRC (longitudinal XOR word).
//  Generate mode: each word gets a row parity bit; after every BLOCK_LEN words an LRC word is inserted.
//  Check mode: verifies the row parity of every beat and the LRC on every (BLOCK_LEN+1)th beat.
//  Keeps a saturating error counter and a sticky flag.
//  Sits between a data source and a serial/link framer, with valid/ready on both sides.
// PARAMETERS
//  DATA_W     8  data word width (>=1)
//  BLOCK_LEN  4  data words per block, excluding the LRC word (>=1)
//  CNT_W      8  error counter width (>=1)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  mode        in   1       0 = generate, 1 = check; sampled at the first beat of each block
//  odd         in   1       0 = even, 1 = odd row parity; sampled with mode
//  clr_err     in   1       clears err_count and err_sticky
//  in_valid    in   1       input beat valid
//  in_ready    out  1       input beat accepted when in_valid && in_ready
//  in_data     in   DATA_W  input word (in check mode, beat BLOCK_LEN+1 is the received LRC)
//  in_parity   in   1       received row parity (check mode only; ignored in generate mode)
//  out_valid   out  1       output beat valid
//  out_ready   in   1       downstream accept
//  out_data    out  DATA_W  word, or LRC on an LRC beat
//  out_parity  out  1       generate mode: computed parity; check mode: in_parity passed through
//  out_lrc     out  1       current beat is the LRC word
//  out_perr    out  1       check mode: row parity error on this beat
//  out_lerr    out  1       check mode: LRC mismatch (LRC beat only)
//  err_count   out  CNT_W   count of beats with out_perr | out_lerr; saturates at all-ones
//  err_sticky  out  1       set on any error beat; held until clr_err or rst
// BEHAVIOUR
//  - Reset values: all outputs 0 except in_ready = 1. Accumulator, beat count and FSM all clear.
//  - One output register stage, latency 1: an input beat accepted at edge N is valid after edge N.
//    in_ready = (state == S_DATA) && (!out_valid || out_ready), giving full throughput within a block.
//  - Output hold: while out_valid && !out_ready, every out_* signal stays stable.
//  - Row parity p(x) = ^x ^ odd.
//    Generate: out_parity = p(data).
//    Check: out_perr = ^in_data ^ in_parity ^ odd, i.e. 1 when the parity sense is wrong.
//  - Accumulator acc is the XOR of the data words in the block. It clears at block end and on rst.
//  - Beat counter runs 0..BLOCK_LEN-1 in generate mode and 0..BLOCK_LEN in check mode.
//    mode and odd are latched when a beat is accepted with count 0.
//    Changes to mode or odd mid-block are ignored until the next block.
//  - FSM, generate mode:
//    S_DATA -> S_LRC on acceptance of word BLOCK_LEN.
//    In S_LRC: in_ready = 0. When the output register is free, load out_data = acc,
//      out_parity = p(acc), out_lrc = 1. Then clear acc, go to S_DATA.
//    Block throughput is BLOCK_LEN/(BLOCK_LEN+1).
//  - FSM, check mode: always S_DATA.
//    Beat BLOCK_LEN+1 is the LRC beat: out_lrc = 1, out_lerr = (in_data != acc), out_perr is also checked.
//    acc then clears.
//  - Errors are counted once per beat at the input-accept edge, even when both perr and lerr are set.
//    The counter saturates and never wraps.
//    clr_err has priority: an error in the same cycle is dropped (count = 0, sticky = 0).
//  - rst mid-block: the partial block, its pending LRC and the output beat are discarded.
//    The next accepted word is beat 0 of a new block.
//  - BLOCK_LEN = 1: every data word is followed by an LRC equal to that word.
// STRUCTURE
//  - parity_pkg: state enum {S_DATA, S_LRC}, mode constants MODE_GEN/MODE_CHK, function row_par(data, odd).
//  - Sub-module parity_lrc_acc: accumulator plus beat counter. It exposes acc, first_beat and last_beat.
//    The top level holds the FSM, output register and error counter.
// TESTING (DATA_W=8, BLOCK_LEN=4 unless stated)
//  1. Generate/even, out_ready=1, words 0B,0F,01,80
//     -> out_parity 1,0,1,1; then out_data=85, out_parity=1, out_lrc=1; in_ready low for exactly 1 cycle.
//  2. Generate/odd, word 0B -> out_parity=0. Toggle mode mid-block -> no effect until the next block.
//  3. Check/even, (0B,1),(0F,0),(01,1),(80,1),(85,1) -> no errors.
//     Repeat with (0B,0) -> out_perr on beat 1, err_count=1, err_sticky=1.
//  4. Check/even, LRC beat (84,0) -> out_lerr=1, out_perr=0, err_count increments by 1.
//  5. out_ready low 3 cycles mid-block and during the LRC beat
//     -> out_* stable, in_ready low, no beat lost or duplicated.
//  6. CNT_W=2, 5 error beats -> err_count=3. clr_err with a coincident error -> 0.
//     rst after 2 words -> next 4 words produce a full block and the correct LRC.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types, constants and helpers for the parity block codec.
//   state_e    : FSM state, S_DATA passes data beats, S_LRC emits the generated LRC word
//   MODE_GEN   : generate row parity and insert an LRC word after each block
//   MODE_CHK   : check row parity on every beat and the LRC on the last beat of a block
//   row_par()  : row parity of a word (even when odd = 0, odd when odd = 1)
package parity_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_LRC  = 1'b1
  } state_e;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  // row_par takes a fixed-width argument; callers zero-extend, which leaves the XOR
  // reduction unchanged. Data words wider than this are not supported.
  localparam int unsigned MAX_DATA_W = 64;

  function automatic logic row_par(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_lrc_acc.sv
// Block accumulator and beat counter.
//   clk, rst   : clock, synchronous active-high reset
//   beat       : an input beat is accepted this cycle
//   chk        : the accepted beat belongs to a check-mode block
//   acc_clr    : the generated LRC word is being emitted, clear the accumulator
//   data       : accepted input word
//   acc        : XOR of the data words accepted so far in this block
//   first_beat : the next accepted beat is beat 0 of a block
//   last_beat  : the next accepted beat is the last one of the block (LRC beat in check mode)
module parity_lrc_acc
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BLOCK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  input  logic              chk,
  input  logic              acc_clr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] acc,
  output logic              first_beat,
  output logic              last_beat
);

  localparam int unsigned CntW = $clog2(BLOCK_LEN + 1);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  // Check-mode blocks carry one extra beat, the received LRC word.
  assign last_beat  = (cnt_q == (chk ? CntW'(BLOCK_LEN) : CntW'(BLOCK_LEN - 1)));
  assign first_beat = (cnt_q == '0);
  assign acc        = acc_q;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (beat) begin
      cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
      // A check-mode LRC beat closes the block; a generate-mode last word still
      // contributes and the accumulator clears when its LRC leaves.
      acc_d = (chk && last_beat) ? '0 : (acc_q ^ data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/parity_block_codec.sv
// Streaming row-parity generator/checker with a block LRC word.
//   clk, rst             : clock, synchronous active-high reset
//   mode, odd            : generate/check and parity sense, latched on beat 0 of a block
//   clr_err              : clear err_count and err_sticky (wins over a coincident error)
//   in_valid/in_ready    : input handshake; in_data/in_parity input word and parity
//   out_valid/out_ready  : output handshake on a single register stage
//   out_data, out_parity : output word (or LRC) and its parity
//   out_lrc              : output beat is an LRC word
//   out_perr, out_lerr   : check-mode row parity error / LRC mismatch on this beat
//   err_count            : saturating count of error beats
//   err_sticky           : set on any error beat
module parity_block_codec
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BLOCK_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              odd,
  input  logic              clr_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity,
  output logic              out_lrc,
  output logic              out_perr,
  output logic              out_lerr,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky
);

  state_e            state_q, state_d;
  logic              mode_q, odd_q;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_parity_q, out_parity_d;
  logic              out_lrc_q, out_lrc_d;
  logic              out_perr_q, out_perr_d;
  logic              out_lerr_q, out_lerr_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              err_sticky_q, err_sticky_d;

  logic              out_free, accept, lrc_emit;
  logic              mode_eff, odd_eff, chk_beat;
  logic              perr_now, lerr_now;
  logic [DATA_W-1:0] acc;
  logic              first_beat, last_beat;

  parity_lrc_acc #(
    .DATA_W    (DATA_W),
    .BLOCK_LEN (BLOCK_LEN)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .beat       (accept),
    .chk        (chk_beat),
    .acc_clr    (lrc_emit),
    .data       (in_data),
    .acc        (acc),
    .first_beat (first_beat),
    .last_beat  (last_beat)
  );

  // Beat 0 uses the live mode/odd inputs; later beats use the values latched then.
  assign mode_eff = first_beat ? mode : mode_q;
  assign odd_eff  = first_beat ? odd : odd_q;
  assign chk_beat = (mode_eff == MODE_CHK);
  assign out_free = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign perr_now = chk_beat && ((^in_data) ^ in_parity ^ odd_eff);
  assign lerr_now = chk_beat && last_beat && (in_data != acc);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_DATA: if (accept && !chk_beat && last_beat) state_d = S_LRC;
      S_LRC:  if (out_free) state_d = S_DATA;
      default: state_d = S_DATA;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    lrc_emit = 1'b0;
    unique case (state_q)
      S_DATA:  in_ready = out_free;
      S_LRC:   lrc_emit = out_free;
      default: in_ready = 1'b0;
    endcase
  end

  // Output register: load an accepted beat or the generated LRC, otherwise hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_lrc_d    = out_lrc_q;
    out_perr_d   = out_perr_q;
    out_lerr_d   = out_lerr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = in_data;
      out_parity_d = chk_beat ? in_parity : row_par(MAX_DATA_W'(in_data), odd_eff);
      out_lrc_d    = chk_beat && last_beat;
      out_perr_d   = perr_now;
      out_lerr_d   = lerr_now;
    end else if (lrc_emit) begin
      out_valid_d  = 1'b1;
      out_data_d   = acc;
      out_parity_d = row_par(MAX_DATA_W'(acc), odd_q);
      out_lrc_d    = 1'b1;
      out_perr_d   = 1'b0;
      out_lerr_d   = 1'b0;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Error accounting: one count per accepted error beat, clr_err wins.
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (clr_err) begin
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end else if (accept && (perr_now || lerr_now)) begin
      err_sticky_d = 1'b1;
      if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_GEN;
      odd_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      out_lrc_q    <= 1'b0;
      out_perr_q   <= 1'b0;
      out_lerr_q   <= 1'b0;
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      if (accept && first_beat) begin
        mode_q <= mode;
        odd_q  <= odd;
      end
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_lrc_q    <= out_lrc_d;
      out_perr_q   <= out_perr_d;
      out_lerr_q   <= out_lerr_d;
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_lrc    = out_lrc_q;
  assign out_perr   = out_perr_q;
  assign out_lerr   = out_lerr_q;
  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_block_codec.sv
// Directed bench for parity_block_codec (DATA_W=8, BLOCK_LEN=4, CNT_W=2).
module tb_parity_block_codec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       odd = 1'b0;
  logic       clr_err = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_parity = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_parity;
  logic       out_lrc;
  logic       out_perr;
  logic       out_lerr;
  logic [1:0] err_count;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_block_codec #(
    .DATA_W    (8),
    .BLOCK_LEN (4),
    .CNT_W     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .odd        (odd),
    .clr_err    (clr_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_parity  (in_parity),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_lrc    (out_lrc),
    .out_perr   (out_perr),
    .out_lerr   (out_lerr),
    .err_count  (err_count),
    .err_sticky (err_sticky)
  );

  // Present one beat and wait (bounded) for its acceptance. Entered and left at
  // posedge+1; on return the output register holds this beat.
  task automatic send(input logic [7:0] d, input logic p);
    int n;
    bit done;
    n = 0;
    done = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    while (!done && n < 20) begin
      #1;
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%h in_ready never high within 20 cycles", d);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_lrc !== 1'b0 || out_perr !== 1'b0 ||
        out_lerr !== 1'b0 || out_data !== 8'h00 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b rdy=%b lrc=%b perr=%b lerr=%b d=%h p=%b want 0 1 0 0 0 00 0",
               out_valid, in_ready, out_lrc, out_perr, out_lerr, out_data, out_parity);
    end
    checks++;
    if (err_count !== 2'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got cnt=%0d sticky=%b want 0 0", err_count, err_sticky);
    end
  endtask

  task automatic test_gen_even();
    logic [7:0] w [4] = '{8'h0B, 8'h0F, 8'h01, 8'h80};
    logic       p [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    mode = 1'b0;
    odd  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(w[i], 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i] || out_parity !== p[i] || out_lrc !== 1'b0) begin
        errors++;
        $display("FAIL gen_even_word%0d got v=%b d=%h p=%b lrc=%b want 1 %h %b 0",
                 i, out_valid, out_data, out_parity, out_lrc, w[i], p[i]);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL gen_even_lrc_stall got in_ready=%b want 0", in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h85 || out_parity !== 1'b1 || out_lrc !== 1'b1 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL gen_even_lrc got v=%b d=%h p=%b lrc=%b rdy=%b want 1 85 1 1 1",
               out_valid, out_data, out_parity, out_lrc, in_ready);
    end
  endtask

  task automatic test_gen_odd_latch();
    mode = 1'b0;
    odd  = 1'b1;
    send(8'h0B, 1'b0);
    checks++;
    if (out_parity !== 1'b0) begin
      errors++;
      $display("FAIL gen_odd_0B got p=%b want 0", out_parity);
    end
    // mid-block changes must be ignored
    mode = 1'b1;
    odd  = 1'b0;
    send(8'h0F, 1'b0);
    checks++;
    if (out_parity !== 1'b1 || out_perr !== 1'b0 || out_lrc !== 1'b0) begin
      errors++;
      $display("FAIL gen_odd_latched got p=%b perr=%b lrc=%b want 1 0 0",
               out_parity, out_perr, out_lrc);
    end
    send(8'h01, 1'b1);
    send(8'h80, 1'b1);
    cycle();
    checks++;
    if (out_lrc !== 1'b1 || out_data !== 8'h85 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL gen_odd_lrc got lrc=%b d=%h p=%b want 1 85 0", out_lrc, out_data, out_parity);
    end
  endtask

  task automatic test_chk_perr();
    logic [7:0] w [5] = '{8'h0B, 8'h0F, 8'h01, 8'h80, 8'h85};
    logic       p [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    mode = 1'b1;
    odd  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(w[i], p[i]);
      checks++;
      if (out_perr !== 1'b0 || out_lerr !== 1'b0 || out_parity !== p[i] ||
          out_lrc !== (i == 4)) begin
        errors++;
        $display("FAIL chk_clean_beat%0d got perr=%b lerr=%b p=%b lrc=%b want 0 0 %b %b",
                 i, out_perr, out_lerr, out_parity, out_lrc, p[i], (i == 4));
      end
    end
    checks++;
    if (err_count !== 2'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL chk_clean_err got cnt=%0d sticky=%b want 0 0", err_count, err_sticky);
    end
    send(8'h0B, 1'b0);
    checks++;
    if (out_perr !== 1'b1 || err_count !== 2'd1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL chk_perr_beat got perr=%b cnt=%0d sticky=%b want 1 1 1",
               out_perr, err_count, err_sticky);
    end
    for (int i = 1; i < 5; i++) send(w[i], p[i]);
    checks++;
    if (err_count !== 2'd1 || out_lrc !== 1'b1 || out_lerr !== 1'b0) begin
      errors++;
      $display("FAIL chk_perr_block_end got cnt=%0d lrc=%b lerr=%b want 1 1 0",
               err_count, out_lrc, out_lerr);
    end
  endtask

  task automatic test_chk_lerr();
    mode = 1'b1;
    odd  = 1'b0;
    send(8'h0B, 1'b1);
    send(8'h0F, 1'b0);
    send(8'h01, 1'b1);
    send(8'h80, 1'b1);
    send(8'h84, 1'b0);
    checks++;
    if (out_lrc !== 1'b1 || out_lerr !== 1'b1 || out_perr !== 1'b0 || err_count !== 2'd2) begin
      errors++;
      $display("FAIL chk_lerr got lrc=%b lerr=%b perr=%b cnt=%0d want 1 1 0 2",
               out_lrc, out_lerr, out_perr, err_count);
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0;
    odd  = 1'b0;
    send(8'h0B, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h0B || out_parity !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_data_hold%0d got v=%b d=%h p=%b rdy=%b want 1 0B 1 0",
                 k, out_valid, out_data, out_parity, in_ready);
      end
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h0F || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got v=%b d=%h p=%b want 1 0F 0", out_valid, out_data, out_parity);
    end
    send(8'h01, 1'b0);
    send(8'h80, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h80 || out_lrc !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_lrc_hold%0d got v=%b d=%h lrc=%b rdy=%b want 1 80 0 0",
                 k, out_valid, out_data, out_lrc, in_ready);
      end
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h85 || out_lrc !== 1'b1) begin
      errors++;
      $display("FAIL bp_lrc_out got v=%b d=%h lrc=%b want 1 85 1", out_valid, out_data, out_lrc);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturate_clear();
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    checks++;
    if (err_count !== 2'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL clr_err got cnt=%0d sticky=%b want 0 0", err_count, err_sticky);
    end
    mode = 1'b1;
    odd  = 1'b0;
    send(8'h0B, 1'b0);
    send(8'h0F, 1'b1);
    send(8'h01, 1'b0);
    send(8'h80, 1'b0);
    send(8'h85, 1'b0);
    checks++;
    if (err_count !== 2'd3 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL saturate got cnt=%0d sticky=%b want 3 1", err_count, err_sticky);
    end
    clr_err = 1'b1;
    send(8'h0B, 1'b0);
    clr_err = 1'b0;
    checks++;
    if (err_count !== 2'd0 || err_sticky !== 1'b0 || out_perr !== 1'b1) begin
      errors++;
      $display("FAIL clr_priority got cnt=%0d sticky=%b perr=%b want 0 0 1",
               err_count, err_sticky, out_perr);
    end
  endtask

  task automatic test_rst_mid_block();
    pulse_rst();
    mode = 1'b0;
    odd  = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    pulse_rst();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_outputs got v=%b rdy=%b d=%h want 0 1 00", out_valid, in_ready, out_data);
    end
    send(8'h0B, 1'b0);
    send(8'h0F, 1'b0);
    cycle();
    checks++;
    if (out_lrc !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_no_early_lrc got lrc=%b rdy=%b want 0 1", out_lrc, in_ready);
    end
    send(8'h01, 1'b0);
    send(8'h80, 1'b0);
    cycle();
    checks++;
    if (out_lrc !== 1'b1 || out_data !== 8'h85 || out_parity !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_lrc got lrc=%b d=%h p=%b want 1 85 1", out_lrc, out_data, out_parity);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    cycle();
    test_gen_even();
    test_gen_odd_latch();
    test_chk_perr();
    test_chk_lerr();
    test_backpressure();
    test_saturate_clear();
    test_rst_mid_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
